// File: rtl/top_deserializer.sv
// Serial-to-parallel receiver: rebuilds MSB-first frames of MIN_LEN..DATA_W bits
// into a left-aligned parallel word plus its length (mod DATA_W).
module top_deserializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_ser_data,
  input  logic              i_ser_data_val,
  output logic [DATA_W-1:0] o_deser_data,
  output logic [MOD_W-1:0]  o_deser_data_mod,
  output logic              o_deser_data_val,
  output logic              o_busy,
  output logic              o_drop
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [DATA_W-1:0] TOP_BIT  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [MOD_W:0]    CNT_LAST = (MOD_W+1)'(DATA_W-1);
  localparam logic [MOD_W:0]    CNT_MIN  = (MOD_W+1)'(MIN_LEN);
  localparam logic [MOD_W:0]    CNT_ONE  = (MOD_W+1)'(1);

  state_t              state_q, state_d;
  logic [MOD_W:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MOD_W-1:0]    mod_q, mod_d;
  logic                val_q, val_d;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   bit_mask;
  logic [DATA_W-1:0]   sr_ins;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    data_d   = data_q;
    mod_d    = mod_q;
    val_d    = 1'b0;
    drop_d   = 1'b0;
    // Unreceived positions are already zero, so inserting a bit is a plain OR.
    bit_mask = TOP_BIT >> cnt_q;
    sr_ins   = sr_q | (i_ser_data ? bit_mask : '0);

    unique case (state_q)
      IDLE: begin
        if (i_ser_data_val) begin
          sr_d    = i_ser_data ? TOP_BIT : '0;
          cnt_d   = CNT_ONE;
          state_d = RECV;
        end
      end
      RECV: begin
        if (i_ser_data_val) begin
          sr_d  = sr_ins;
          cnt_d = cnt_q + CNT_ONE;
          // Full-length frame closes on the same edge as its last bit.
          if (cnt_q == CNT_LAST) begin
            data_d  = sr_ins;
            mod_d   = '0;
            val_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          if (cnt_q >= CNT_MIN) begin
            data_d = sr_q;
            mod_d  = cnt_q[MOD_W-1:0];
            val_d  = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
    end
  end

  assign o_deser_data     = data_q;
  assign o_deser_data_mod = mod_q;
  assign o_deser_data_val = val_q;
  assign o_drop           = drop_q;
  assign o_busy           = (state_q == RECV);

endmodule

// File: tb/tb_top_deserializer.sv
// Directed bench for top_deserializer: reset, full/short/too-short frames,
// gap handling and a serializer-style loopback with masked expectations.
module tb_top_deserializer;

  logic        clk;
  logic        i_rst_n;
  logic        i_ser_data;
  logic        i_ser_data_val;
  logic [15:0] o_deser_data;
  logic [3:0]  o_deser_data_mod;
  logic        o_deser_data_val;
  logic        o_busy;
  logic        o_drop;

  top_deserializer dut (
    .clk              (clk),
    .i_rst_n          (i_rst_n),
    .i_ser_data       (i_ser_data),
    .i_ser_data_val   (i_ser_data_val),
    .o_deser_data     (o_deser_data),
    .o_deser_data_mod (o_deser_data_mod),
    .o_deser_data_val (o_deser_data_val),
    .o_busy           (o_busy),
    .o_drop           (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
    int          e;
  } ev_t;

  ev_t evq[$];
  int  drops;
  int  cyc;
  int  last_edge;
  int  n_vec;
  int  n_miscmp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_deser_data_val) begin
      ev_t ev;
      ev.d = o_deser_data;
      ev.m = o_deser_data_mod;
      ev.e = cyc;
      evq.push_back(ev);
    end
    if (o_drop) drops++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    i_ser_data     = b;
    i_ser_data_val = 1'b1;
    last_edge      = cyc + 1;
  endtask

  task automatic send_word(input logic [15:0] w, input int len);
    for (int i = 0; i < len; i++) send_bit(w[15-i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_ser_data     = 1'b0;
      i_ser_data_val = 1'b0;
    end
  endtask

  task automatic clear_log();
    evq.delete();
    drops = 0;
  endtask

  task automatic chk_ev(input string tag, input int idx, input logic [15:0] d, input logic [3:0] m);
    if (evq.size() > idx) begin
      chk({tag, "_data"}, 32'(evq[idx].d), 32'(d));
      chk({tag, "_mod"},  32'(evq[idx].m), 32'(m));
    end else begin
      chk({tag, "_present"}, 32'(evq.size()), 32'(idx + 1));
    end
  endtask

  logic [15:0] lw [8];
  int          ll [8];
  int          edge_a;

  initial begin
    cyc            = 0;
    n_vec          = 0;
    n_miscmp       = 0;
    drops          = 0;
    last_edge      = 0;
    i_rst_n        = 1'b0;
    i_ser_data     = 1'b0;
    i_ser_data_val = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(o_deser_data), 32'h0);
    chk("rst_mod",  32'(o_deser_data_mod), 32'h0);
    chk("rst_val",  32'(o_deser_data_val), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_drop", 32'(o_drop), 32'h0);
    i_rst_n = 1'b1;
    idle(2);

    // Two back-to-back 16-bit frames
    clear_log();
    send_word(16'hA5C3, 16);
    edge_a = last_edge;
    send_word(16'h1234, 16);
    idle(3);
    chk("full_count", 32'(evq.size()), 32'd2);
    chk_ev("full0", 0, 16'hA5C3, 4'd0);
    chk_ev("full1", 1, 16'h1234, 4'd0);
    if (evq.size() == 2) begin
      chk("full_lat",    32'(evq[0].e - edge_a), 32'd0);
      chk("full_period", 32'(evq[1].e - evq[0].e), 32'd16);
    end

    // Reset in the middle of a frame
    clear_log();
    send_word(16'hB000, 5);
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(o_busy), 32'h1);
    chk("mid_hold", 32'(o_deser_data), 32'h1234);
    i_rst_n        = 1'b0;
    i_ser_data_val = 1'b0;
    #1;
    chk("arst_data", 32'(o_deser_data), 32'h0);
    chk("arst_busy", 32'(o_busy), 32'h0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    idle(4);
    chk("arst_noval",  32'(evq.size()), 32'd0);
    chk("arst_nodrop", 32'(drops), 32'd0);

    // Short frames: 5 bits and 3 bits
    clear_log();
    send_word(16'hB000, 5);
    edge_a = last_edge;
    idle(3);
    chk("short5_count", 32'(evq.size()), 32'd1);
    chk_ev("short5", 0, 16'hB000, 4'd5);
    if (evq.size() == 1) chk("short5_lat", 32'(evq[0].e - edge_a), 32'd1);
    chk("short5_busy", 32'(o_busy), 32'h0);
    clear_log();
    send_word(16'hA000, 3);
    idle(3);
    chk_ev("short3", 0, 16'hA000, 4'd3);

    // Too-short frames are dropped and outputs hold
    clear_log();
    send_word(16'h8000, 1);
    idle(2);
    send_word(16'hC000, 2);
    idle(3);
    chk("drop_count",  32'(drops), 32'd2);
    chk("drop_noval",  32'(evq.size()), 32'd0);
    chk("drop_hold_d", 32'(o_deser_data), 32'hA000);
    chk("drop_hold_m", 32'(o_deser_data_mod), 32'd3);

    // Gap handling: one idle cycle separates, zero gap merges
    clear_log();
    send_word(16'hF000, 4);
    idle(1);
    send_word(16'h0000, 4);
    idle(3);
    chk("gap1_count", 32'(evq.size()), 32'd2);
    chk_ev("gap1_a", 0, 16'hF000, 4'd4);
    chk_ev("gap1_b", 1, 16'h0000, 4'd4);
    clear_log();
    send_word(16'hF000, 4);
    send_word(16'h0000, 4);
    idle(3);
    chk("gap0_count", 32'(evq.size()), 32'd1);
    chk_ev("gap0", 0, 16'hF000, 4'd8);

    // Loopback: random words and lengths 3..16, masked to the top len bits
    clear_log();
    for (int f = 0; f < 8; f++) begin
      lw[f] = 16'($urandom);
      ll[f] = (f == 0) ? 16 : ((f == 1) ? 3 : int'($urandom_range(3, 16)));
      send_word(lw[f], ll[f]);
      idle(1);
    end
    idle(3);
    chk("loop_count", 32'(evq.size()), 32'd8);
    chk("loop_nodrop", 32'(drops), 32'd0);
    for (int f = 0; f < 8; f++) begin
      logic [15:0] m;
      m = 16'hFFFF << (16 - ll[f]);
      chk_ev($sformatf("loop%0d", f), f, lw[f] & m, 4'(ll[f]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/top_deserializer.md
# top_deserializer

Serial-to-parallel receiver for the serializer's output stream. It rebuilds each frame of 3 to 16 bits into a parallel word. A frame is one contiguous run of valid bits, sent MSB first. For each frame the block reports the word and its bit count in the same 4-bit encoding the serializer accepts, where 0 means 16. It sits on the receive side of the serial link and drives the downstream parallel consumer.

## Interface
- `DATA_W`, default 16: maximum frame length and width of the parallel word.
- `MOD_W`, default `$clog2(DATA_W)` = 4: width of the length field.
- `MIN_LEN`, default 3: shortest legal frame. Shorter frames are dropped.

Ports:
- `clk`, in, 1: the single clock. Everything samples on the rising edge.
- `i_rst_n`, in, 1: reset, asynchronous assert, active-low. Deassertion must be synchronised to `clk` upstream.
- `i_ser_data`, in, 1: serial bit. Sampled only when `i_ser_data_val` = 1.
- `i_ser_data_val`, in, 1: marks `i_ser_data` as a valid bit. A frame is a maximal run of cycles with this signal high, capped at `DATA_W` bits.
- `o_deser_data`, out, DATA_W: reconstructed word. The first received bit is at bit `DATA_W-1`. Bit positions that were not received read 0.
- `o_deser_data_mod`, out, MOD_W: bit count of the frame, mod `DATA_W`. A value of 0 means `DATA_W` bits.
- `o_deser_data_val`, out, 1: one-cycle pulse qualifying `o_deser_data` and `o_deser_data_mod`.
- `o_busy`, out, 1: high while a frame is partially received.
- `o_drop`, out, 1: one-cycle pulse when a frame shorter than `MIN_LEN` is discarded.

## Operation
- Two states, IDLE and RECV. Counter `cnt` is `MOD_W+1` bits. Shift register `sr` is `DATA_W` bits.
- **IDLE, `i_ser_data_val` = 1:**
  - set `sr` = `{i_ser_data, {DATA_W-1{1'b0}}}`;
  - set `cnt` = 1;
  - go to RECV.
- **RECV, `i_ser_data_val` = 1:**
  - write the bit at position `DATA_W-1-cnt`, so earlier bits keep their positions;
  - increment `cnt`.
- **RECV, `cnt` reaches `DATA_W`:** when the bit that brings `cnt` to `DATA_W` is written, that same edge does all of the following:
  - loads the outputs;
  - pulses `o_deser_data_val`;
  - sets `o_deser_data_mod` = 0;
  - returns to IDLE.
  
  If `i_ser_data_val` is still high on the next cycle, that bit starts a new frame.
- **RECV, `i_ser_data_val` = 0:** the frame ends.
  - If `cnt` ≥ `MIN_LEN`: load `o_deser_data` = `sr`, set `o_deser_data_mod` = `cnt[MOD_W-1:0]`, pulse `o_deser_data_val`.
  - Otherwise: pulse `o_drop`; the output word and length hold their values.
  - In both cases, clear `cnt` and return to IDLE.
- **Frame separation:** frames shorter than `DATA_W` need at least one cycle of `i_ser_data_val` low between them. Without that gap they merge into one frame, and this is the defined behaviour.
- **Output registers:**
  - `o_deser_data` and `o_deser_data_mod` hold their last value until the next good frame.
  - `o_deser_data_val` and `o_drop` are high for exactly one cycle per event.
- `o_busy` = 1 exactly when the state is RECV.
- **Reset (`i_rst_n` low, at any time, including mid-frame):** the state, counter and all outputs are set immediately as below. Any partial frame is discarded with no `o_drop` pulse.
  - state = IDLE, `cnt` = 0, `sr` = 0;
  - `o_deser_data` = 0, `o_deser_data_mod` = 0;
  - `o_deser_data_val` = 0, `o_busy` = 0, `o_drop` = 0.

## Timing
- **Full frame:** the `DATA_W`th bit is sampled at edge k; `o_deser_data_val` is high in the cycle after edge k, so latency is 1 cycle.
- **Short frame:**
  - the last bit is sampled at edge k;
  - `i_ser_data_val` is sampled low at edge k+1;
  - `o_deser_data_val` or `o_drop` is high in the cycle after edge k+1.
- **Throughput:** back-to-back 16-bit frames give one pulse every 16 cycles. Gapped short frames need a minimum period of length + 1 cycles.
- **`o_busy`:** rises in the cycle after the first bit is sampled and falls in the same cycle the output pulse appears.
- **Ordering:** the counter wraps from 16 only through the IDLE return, never by arithmetic overflow. An end of frame and a new first bit can never fall on the same edge, since `i_ser_data_val` is low at the ending edge.
- **Output timing:** all outputs are registered, with no combinational path from input to output.

## Test plan
- **Reset:** hold `i_rst_n` = 0, then release.
  - Required: all outputs 0, `o_busy` = 0.
  - Then assert `i_rst_n` = 0 after 5 bits of a frame: outputs clear at once, and no `o_deser_data_val` or `o_drop` follows.
- **16-bit frame:** send 0xA5C3 MSB first over 16 contiguous cycles.
  - Required: one `o_deser_data_val` pulse 1 cycle after the last bit, with data = 0xA5C3 and mod = 0.
  - Then send 0x1234 with no gap: a second pulse 16 cycles later with data = 0x1234.
- **Short frame:** send 5 bits, 1,0,1,1,0, then drop val.
  - Required: pulse with data = 0xB000 and mod = 5, 2 cycles after the last bit.
  - Also send a 3-bit frame: mod = 3.
- **Too short:** send frames of 1 and 2 bits.
  - Required: an `o_drop` pulse for each and no `o_deser_data_val`.
  - Output data and mod keep their previous values.
- **Gap handling:** send two 4-bit frames, 0xF and 0x0, separated by one idle cycle.
  - Required: two pulses, data 0xF000 then 0x0000, both with mod = 4.
  - Repeat with zero gap: one pulse with mod = 8 and data = 0xF000.
- **Loopback with serializer wrapper:** drive the serializer wrapper with random data and mod values from 3 to 16, and feed its serial output into this block.
  - Required: every word and its mod match the input word masked to the top mod bits.
  - `o_drop` never pulses.
